// File: rtl/qblock_if.sv
// qblock_if: bundles the pixel position, level selection, block geometry, player
// state and every block output into one port.
// The slave side is the question-block controller.
// The master side is whatever drives the block: the game top level, or the bench.
interface qblock_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [2:0] level_num;
    logic [2:0] qblock_level_num;
    logic [9:0] block_x;
    logic [9:0] block_y;
    logic [9:0] mario_x;
    logic [9:0] mario_y;
    logic [9:0] luigi_x;
    logic [9:0] luigi_y;
    logic [9:0] mario_Size_Y;
    logic [9:0] luigi_Size_Y;
    logic [1:0] mario_health;
    logic [1:0] luigi_health;
    logic       is_qblock_empty;
    logic [9:0] start_x;
    logic [9:0] start_y;
    logic       bump_pulse;
    logic [1:0] hit_player;
    logic [2:0] bump_offset;
    logic       is_qblock;
    logic [8:0] qblock_address;

    modport master (
        output DrawX, DrawY, level_num, qblock_level_num, block_x, block_y,
               mario_x, mario_y, luigi_x, luigi_y, mario_Size_Y, luigi_Size_Y,
               mario_health, luigi_health,
        input  is_qblock_empty, start_x, start_y, bump_pulse, hit_player,
               bump_offset, is_qblock, qblock_address
    );

    modport slave (
        input  DrawX, DrawY, level_num, qblock_level_num, block_x, block_y,
               mario_x, mario_y, luigi_x, luigi_y, mario_Size_Y, luigi_Size_Y,
               mario_health, luigi_health,
        output is_qblock_empty, start_x, start_y, bump_pulse, hit_player,
               bump_offset, is_qblock, qblock_address
    );
endinterface

// File: rtl/qblock.sv
// qblock: question-block controller (FULL -> BUMP -> EMPTY).
// It detects a player striking the block from below.
// It plays the bump animation, then latches the block empty.
// Latching empty releases the matching power-up.
// It also produces the per-pixel hit test and the sprite ROM address for the tile.
// Optional feature macro: QBLOCK_BUMP_ANIM_EN.
//   Defined:     a hit enters BUMP and runs the 8-frame offset animation.
//   Not defined: a hit goes straight to EMPTY, and bump_offset stays 0.
module qblock (
    input  logic     frame_clk,
    input  logic     Reset,
    qblock_if.slave  bus
);

`ifdef QBLOCK_BUMP_ANIM_EN
    typedef enum logic [1:0] {
        ST_FULL  = 2'd0,
        ST_BUMP  = 2'd1,
        ST_EMPTY = 2'd2
    } state_t;

    // Upward displacement for each frame of the bump animation.
    function automatic logic [2:0] bump_table(input logic [2:0] idx);
        logic [2:0] off;
        case (idx)
            3'd0:    off = 3'd2;
            3'd1:    off = 3'd4;
            3'd2:    off = 3'd6;
            3'd3:    off = 3'd6;
            3'd4:    off = 3'd4;
            3'd5:    off = 3'd2;
            default: off = 3'd0;
        endcase
        return off;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_FULL  = 2'd0,
        ST_EMPTY = 2'd2
    } state_t;
`endif

    // Hit test for one player, evaluated in 11 bits so that the sums cannot wrap.
    // A head above the top of the screen (y < size_y) never scores a hit.
    function automatic logic player_hit(
        input logic [9:0]  x,
        input logic [9:0]  y,
        input logic [9:0]  size_y,
        input logic [10:0] prev_head,
        input logic [1:0]  health,
        input logic [9:0]  bx,
        input logic [9:0]  by
    );
        logic [10:0] head;
        logic        x_ok;
        logic        y_ok;
        head = {1'b0, y} - {1'b0, size_y};
        x_ok = (({1'b0, x} + 11'd14) > {1'b0, bx}) && ({1'b0, x} < ({1'b0, bx} + 11'd14));
        y_ok = (head >= ({1'b0, by} + 11'd6)) && (head <= ({1'b0, by} + 11'd10));
        return (y >= size_y) && (health != 2'd0) && x_ok && y_ok && (head < prev_head);
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic        empty_r;
    logic        pulse_r;
    logic        pulse_next_s;
    logic [1:0]  hit_player_r;
    logic [1:0]  hit_player_next_s;
    logic [2:0]  bump_offset_r;
    logic [2:0]  offset_next_s;
`ifdef QBLOCK_BUMP_ANIM_EN
    logic [2:0]  bump_cnt_r;
    logic [2:0]  cnt_next_s;
`endif
    logic [10:0] prev_head_m_r;
    logic [10:0] prev_head_l_r;
    logic        track_valid_r;
    logic        in_level_s;
    logic [10:0] head_m_s;
    logic [10:0] head_l_s;
    logic [1:0]  hit_vec_s;
    logic [11:0] px_s;
    logic [11:0] py_s;
    logic        is_qblock_s;
    logic [8:0]  address_s;

    assign in_level_s = (bus.level_num == bus.qblock_level_num);
    assign head_m_s   = {1'b0, bus.mario_y} - {1'b0, bus.mario_Size_Y};
    assign head_l_s   = {1'b0, bus.luigi_y} - {1'b0, bus.luigi_Size_Y};

    // Qualify each player's strike. Only a FULL, in-level block with valid head history accepts a hit.
    always_comb begin
        hit_vec_s = 2'b00;
        if (in_level_s && (state_r == ST_FULL) && track_valid_r) begin
            hit_vec_s[0] = player_hit(bus.mario_x, bus.mario_y, bus.mario_Size_Y, prev_head_m_r,
                                      bus.mario_health, bus.block_x, bus.block_y);
            hit_vec_s[1] = player_hit(bus.luigi_x, bus.luigi_y, bus.luigi_Size_Y, prev_head_l_r,
                                      bus.luigi_health, bus.block_x, bus.block_y);
        end else begin
            hit_vec_s = 2'b00;
        end
    end

    // Next-state and next-output logic for the FULL/BUMP/EMPTY sequence.
    always_comb begin
        state_next_s      = state_r;
        pulse_next_s      = 1'b0;
        hit_player_next_s = hit_player_r;
        offset_next_s     = 3'd0;
`ifdef QBLOCK_BUMP_ANIM_EN
        cnt_next_s        = bump_cnt_r;
`endif
        case (state_r)
            ST_FULL: begin
                if (hit_vec_s != 2'b00) begin
                    pulse_next_s      = 1'b1;
                    hit_player_next_s = hit_vec_s;
`ifdef QBLOCK_BUMP_ANIM_EN
                    state_next_s      = ST_BUMP;
                    cnt_next_s        = 3'd0;
                    offset_next_s     = bump_table(3'd0);
`else
                    state_next_s      = ST_EMPTY;
`endif
                end else begin
                    state_next_s = ST_FULL;
                end
            end
`ifdef QBLOCK_BUMP_ANIM_EN
            ST_BUMP: begin
                // Leaving the level cuts the animation short, but the contents still count as delivered.
                if (!in_level_s) begin
                    state_next_s = ST_EMPTY;
                end else if (bump_cnt_r == 3'd7) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    cnt_next_s    = bump_cnt_r + 3'd1;
                    offset_next_s = bump_table(bump_cnt_r + 3'd1);
                end
            end
`endif
            ST_EMPTY: begin
                state_next_s = ST_EMPTY;
            end
            default: begin
                state_next_s = ST_FULL;
            end
        endcase
    end

    // State register. Only Reset can take the block out of EMPTY.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_FULL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered block outputs, updated alongside the state.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            empty_r       <= 1'b0;
            pulse_r       <= 1'b0;
            hit_player_r  <= 2'b00;
            bump_offset_r <= 3'd0;
        end else begin
            empty_r       <= (state_next_s == ST_EMPTY);
            pulse_r       <= pulse_next_s;
            hit_player_r  <= hit_player_next_s;
            bump_offset_r <= offset_next_s;
        end
    end

`ifdef QBLOCK_BUMP_ANIM_EN
    // Animation frame counter.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            bump_cnt_r <= 3'd0;
        end else begin
            bump_cnt_r <= cnt_next_s;
        end
    end
`endif

    // Head history, used to tell upward motion from downward motion.
    // History is only trusted after one full in-level frame.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            prev_head_m_r <= 11'd0;
            prev_head_l_r <= 11'd0;
            track_valid_r <= 1'b0;
        end else begin
            prev_head_m_r <= head_m_s;
            prev_head_l_r <= head_l_s;
            track_valid_r <= in_level_s;
        end
    end

    // Tile-relative pixel coordinates. A negative result wraps far above 19 and falls outside the tile.
    always_comb begin
        px_s = {2'b00, bus.DrawX} - {2'b00, bus.block_x} + 12'd10;
        py_s = {2'b00, bus.DrawY} - {2'b00, bus.block_y} + {9'd0, bump_offset_r} + 12'd10;
        if (in_level_s && (px_s < 12'd20) && (py_s < 12'd20)) begin
            is_qblock_s = 1'b1;
            address_s   = px_s[8:0] + (9'd20 * py_s[8:0]);
        end else begin
            is_qblock_s = 1'b0;
            address_s   = 9'd0;
        end
    end

    assign bus.is_qblock_empty = empty_r;
    assign bus.bump_pulse      = pulse_r;
    assign bus.hit_player      = hit_player_r;
    assign bus.bump_offset     = bump_offset_r;
    assign bus.start_x         = bus.block_x;
    assign bus.start_y         = bus.block_y - 10'd20;
    assign bus.is_qblock       = is_qblock_s;
    assign bus.qblock_address  = address_s;

endmodule

// File: tb/tb_qblock.sv
// tb_qblock: table-driven and randomized bench for the question-block controller.
// A frame-level reference model predicts every registered output and the render path each frame.
module tb_qblock;
    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    always #5 frame_clk = ~frame_clk;

    qblock_if bus();

    qblock u_dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

`ifdef QBLOCK_BUMP_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int bump_seq[8] = '{2, 4, 6, 6, 4, 2, 0, 0};

    // Reference model: the block is FULL, bumping (frames since the hit), or EMPTY.
    bit m_empty;
    bit m_bumping;
    bit m_pulse;
    bit m_track;
    int m_age;
    int m_hitp;
    int m_prev_m;
    int m_prev_l;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_empty = 0; m_bumping = 0; m_pulse = 0; m_track = 0;
        m_age = 0; m_hitp = 0; m_prev_m = 0; m_prev_l = 0;
    endtask

    function automatic bit model_hit(int x, int y, int sz, int hp, int prev);
        int head;
        int bx;
        int by;
        bx   = int'(bus.block_x);
        by   = int'(bus.block_y);
        head = y - sz;
        if (y < sz) return 0;
        return (hp != 0) && (x + 14 > bx) && (x < bx + 14) &&
               (head >= by + 6) && (head <= by + 10) && (head < prev);
    endfunction

    // Advance the model by one frame, using the inputs applied for that frame.
    task automatic model_step();
        bit in_lvl;
        bit full;
        bit hm;
        bit hl;
        in_lvl = (bus.level_num == bus.qblock_level_num);
        full   = !m_empty && !m_bumping;
        hm = in_lvl && full && m_track &&
             model_hit(int'(bus.mario_x), int'(bus.mario_y), int'(bus.mario_Size_Y),
                       int'(bus.mario_health), m_prev_m);
        hl = in_lvl && full && m_track &&
             model_hit(int'(bus.luigi_x), int'(bus.luigi_y), int'(bus.luigi_Size_Y),
                       int'(bus.luigi_health), m_prev_l);
        m_pulse = 0;
        if (m_bumping) begin
            if (!in_lvl) begin
                m_bumping = 0; m_empty = 1;
            end else begin
                m_age++;
                if (m_age == 8) begin
                    m_bumping = 0; m_empty = 1;
                end
            end
        end else if (full && (hm || hl)) begin
            m_pulse = 1;
            m_hitp  = (hl ? 2 : 0) + (hm ? 1 : 0);
            if (ANIM) begin
                m_bumping = 1; m_age = 0;
            end else begin
                m_empty = 1;
            end
        end
        m_prev_m = (int'(bus.mario_y) - int'(bus.mario_Size_Y)) & 2047;
        m_prev_l = (int'(bus.luigi_y) - int'(bus.luigi_Size_Y)) & 2047;
        m_track  = in_lvl;
    endtask

    task automatic check_all(input string tag);
        int off;
        int px;
        int py;
        bit in_t;
        off  = m_bumping ? bump_seq[m_age] : 0;
        px   = int'(bus.DrawX) - int'(bus.block_x) + 10;
        py   = int'(bus.DrawY) - (int'(bus.block_y) - off) + 10;
        in_t = (bus.level_num == bus.qblock_level_num) && px >= 0 && px <= 19 && py >= 0 && py <= 19;
        check({tag, ".empty"},   int'(bus.is_qblock_empty), int'(m_empty));
        check({tag, ".pulse"},   int'(bus.bump_pulse), int'(m_pulse));
        check({tag, ".hitp"},    int'(bus.hit_player), m_hitp);
        check({tag, ".offset"},  int'(bus.bump_offset), off);
        check({tag, ".start_x"}, int'(bus.start_x), int'(bus.block_x));
        check({tag, ".start_y"}, int'(bus.start_y), (int'(bus.block_y) - 20) & 1023);
        check({tag, ".is_qb"},   int'(bus.is_qblock), int'(in_t));
        check({tag, ".addr"},    int'(bus.qblock_address), in_t ? px + 20 * py : 0);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge frame_clk);
        @(negedge frame_clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        #1;
        check_all("rst");
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic set_defaults();
        bus.DrawX = 10'd0;          bus.DrawY = 10'd0;
        bus.level_num = 3'd1;       bus.qblock_level_num = 3'd1;
        bus.block_x = 10'd200;      bus.block_y = 10'd200;
        bus.mario_x = 10'd600;      bus.mario_y = 10'd500;
        bus.luigi_x = 10'd600;      bus.luigi_y = 10'd500;
        bus.mario_Size_Y = 10'd10;  bus.luigi_Size_Y = 10'd10;
        bus.mario_health = 2'd3;    bus.luigi_health = 2'd3;
    endtask

    typedef struct {
        int dx;
        int dy;
        bit lvl;
        bit exp_is;
        int exp_addr;
    } render_vec_t;

    typedef struct {
        int mx;
        int y0;
        int y1;
        int hp;
        bit exp_hit;
    } hit_vec_t;

    render_vec_t rvec[9];
    hit_vec_t    hvec[10];

    initial begin
        rvec[0] = '{190, 190, 1, 1, 0};
        rvec[1] = '{209, 209, 1, 1, 399};
        rvec[2] = '{189, 190, 1, 0, 0};
        rvec[3] = '{210, 200, 1, 0, 0};
        rvec[4] = '{200, 200, 1, 1, 210};
        rvec[5] = '{190, 189, 1, 0, 0};
        rvec[6] = '{195, 192, 1, 1, 45};
        rvec[7] = '{209, 210, 1, 0, 0};
        rvec[8] = '{200, 200, 0, 0, 0};

        hvec[0] = '{200, 228, 216, 3, 1};
        hvec[1] = '{200, 214, 216, 3, 0};
        hvec[2] = '{200, 228, 216, 0, 0};
        hvec[3] = '{186, 228, 216, 3, 0};
        hvec[4] = '{187, 228, 216, 3, 1};
        hvec[5] = '{213, 228, 216, 3, 1};
        hvec[6] = '{214, 228, 216, 3, 0};
        hvec[7] = '{200, 230, 221, 3, 0};
        hvec[8] = '{200, 230, 220, 3, 1};
        hvec[9] = '{200, 228, 215, 3, 0};

        set_defaults();
        do_reset();
        check("reset.empty", int'(bus.is_qblock_empty), 0);
        check("reset.hitp", int'(bus.hit_player), 0);

        // Render table, taken with the block FULL and undisplaced.
        foreach (rvec[i]) begin
            bus.DrawX = rvec[i].dx[9:0];
            bus.DrawY = rvec[i].dy[9:0];
            bus.level_num = rvec[i].lvl ? 3'd1 : 3'd2;
            #1;
            check($sformatf("render%0d.is", i), int'(bus.is_qblock), int'(rvec[i].exp_is));
            check($sformatf("render%0d.addr", i), int'(bus.qblock_address), rvec[i].exp_addr);
        end
        bus.level_num = 3'd1;

        // Hit-condition table: one frame sets up head history, the next frame is the strike.
        foreach (hvec[i]) begin
            set_defaults();
            do_reset();
            bus.mario_x = hvec[i].mx[9:0];
            bus.mario_y = hvec[i].y0[9:0];
            bus.mario_health = hvec[i].hp[1:0];
            tick("hv_setup");
            bus.mario_y = hvec[i].y1[9:0];
            tick("hv_hit");
            check($sformatf("hitvec%0d.pulse", i), int'(bus.bump_pulse), int'(hvec[i].exp_hit));
            check($sformatf("hitvec%0d.hitp", i), int'(bus.hit_player), hvec[i].exp_hit ? 1 : 0);
        end

        // Mario strikes the block: full offset sequence, then EMPTY.
        set_defaults();
        do_reset();
        bus.mario_x = 10'd200; bus.mario_y = 10'd228;
        tick("A0");
        bus.mario_y = 10'd216;
        tick("A1");
        check("A.pulse", int'(bus.bump_pulse), 1);
        check("A.hitp", int'(bus.hit_player), 1);
        check("A.off0", int'(bus.bump_offset), ANIM ? 2 : 0);
        check("A.empty0", int'(bus.is_qblock_empty), ANIM ? 0 : 1);
        for (int k = 1; k < 8; k++) begin
            tick("A_seq");
            check($sformatf("A.off%0d", k), int'(bus.bump_offset), ANIM ? bump_seq[k] : 0);
            check("A.pulse_low", int'(bus.bump_pulse), 0);
            if (ANIM && k == 2) begin
                bus.DrawX = 10'd190; bus.DrawY = 10'd184; #1;
                check("A.r6.is_tl", int'(bus.is_qblock), 1);
                check("A.r6.addr_tl", int'(bus.qblock_address), 0);
                bus.DrawX = 10'd209; bus.DrawY = 10'd203; #1;
                check("A.r6.addr_br", int'(bus.qblock_address), 399);
                bus.DrawY = 10'd204; #1;
                check("A.r6.is_below", int'(bus.is_qblock), 0);
            end
        end
        tick("A_end");
        check("A.empty", int'(bus.is_qblock_empty), 1);

        // Both players strike on the same frame, then the level is left mid-bump.
        set_defaults();
        do_reset();
        bus.mario_x = 10'd200; bus.mario_y = 10'd228;
        bus.luigi_x = 10'd200; bus.luigi_y = 10'd228;
        tick("B0");
        bus.mario_y = 10'd216; bus.luigi_y = 10'd216;
        tick("B1");
        check("B.hitp", int'(bus.hit_player), 3);
        check("B.pulse", int'(bus.bump_pulse), 1);
        tick("B2");
        check("B.pulse_once", int'(bus.bump_pulse), 0);
        tick("B3");
        tick("B4");
        bus.level_num = 3'd2;
        tick("C0");
        check("C.empty", int'(bus.is_qblock_empty), 1);
        check("C.off", int'(bus.bump_offset), 0);
        bus.level_num = 3'd1;
        bus.DrawX = 10'd200; bus.DrawY = 10'd200;
        tick("C1");
        check("C.empty_kept", int'(bus.is_qblock_empty), 1);
        check("C.drawn", int'(bus.is_qblock), 1);

        // Reset while EMPTY; the first in-level frame cannot hit before head history is valid.
        do_reset();
        check("D.empty", int'(bus.is_qblock_empty), 0);
        check("D.hitp", int'(bus.hit_player), 0);
        bus.level_num = 3'd2;
        bus.mario_x = 10'd200; bus.mario_y = 10'd228;
        bus.luigi_x = 10'd600; bus.luigi_y = 10'd500;
        tick("D0");
        bus.level_num = 3'd1; bus.mario_y = 10'd216;
        tick("D1");
        check("D.first_frame", int'(bus.bump_pulse), 0);
        bus.mario_y = 10'd220;
        tick("D2");
        check("D.down", int'(bus.bump_pulse), 0);
        bus.mario_y = 10'd216;
        tick("D3");
        check("D.hit", int'(bus.bump_pulse), 1);

        // Randomized frames around the block, with occasional resets and level changes.
        set_defaults();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int sz;
            if ($urandom_range(0, 99) == 0) do_reset();
            if ($urandom_range(0, 39) == 0) bus.level_num = 3'($urandom_range(0, 2));
            sz = $urandom_range(5, 15);
            bus.mario_Size_Y = 10'(sz);
            bus.mario_x = 10'($urandom_range(180, 220));
            bus.mario_y = 10'($urandom_range(195, 225) + sz);
            bus.mario_health = 2'($urandom_range(0, 3));
            sz = $urandom_range(5, 15);
            bus.luigi_Size_Y = 10'(sz);
            bus.luigi_x = 10'($urandom_range(180, 220));
            bus.luigi_y = 10'($urandom_range(195, 225) + sz);
            bus.luigi_health = 2'($urandom_range(0, 3));
            bus.DrawX = 10'($urandom_range(185, 215));
            bus.DrawY = 10'($urandom_range(180, 215));
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/qblock.md
# qblock

Question-block controller: the spawning side of the power-up handshake. It owns one "?" block tile per instance, detects Mario or Luigi striking it from below, plays a short bump animation and then latches the block empty. Latching empty drives `is_qblock_empty` and `start_x`/`start_y` into the matching upgrade (mushroom) instance, which releases the power-up. It also produces the per-pixel hit test and sprite address for the block tile.

## Interface
Parameters
- none

Ports
- `frame_clk`  in  1  frame-rate clock; all state updates on its rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `DrawX`, `DrawY`  in  10 each  current VGA pixel
- `level_num`  in  3  level currently displayed
- `qblock_level_num`  in  3  level this block belongs to
- `block_x`, `block_y`  in  10 each  tile centre; the tile spans x∈[block_x−10, block_x+9] and y∈[block_y−10, block_y+9]
- `mario_x`, `mario_y`, `luigi_x`, `luigi_y`  in  10 each  character centres
- `mario_Size_Y`, `luigi_Size_Y`  in  10 each  character half-heights
- `mario_health`, `luigi_health`  in  2 each  0 = dead
- `is_qblock_empty`  out  1  block has delivered its contents (sticky)
- `start_x`, `start_y`  out  10 each  power-up spawn point
- `bump_pulse`  out  1  one frame high on an accepted hit
- `hit_player`  out  2  bit0 = Mario, bit1 = Luigi; captured on hit
- `bump_offset`  out  3  upward render displacement, in pixels
- `is_qblock`  out  1  current pixel is inside the (displaced) tile
- `qblock_address`  out  9  sprite ROM address, 0..399

## Operation
- States: FULL → BUMP → EMPTY. EMPTY is left only by Reset.
- `in_level` = (`level_num` == `qblock_level_num`).
- Head tracking:
  - For each player, head = y − Size_Y, computed in 11 bits.
  - If y < Size_Y, head is invalid and no hit is possible.
  - `prev_head_m` and `prev_head_l` register head every frame.
  - `track_valid` is cleared on Reset and on any frame with !`in_level`. It is set on the first in-level frame.
- Player hit condition (all terms required):
  - `in_level`, state FULL, `track_valid`, health ≠ 0
  - x overlap: x + 14 > `block_x` and x < `block_x` + 14
  - head in [`block_y` + 6, `block_y` + 10]
  - head < prev_head (moving up)
- Mario and Luigi are evaluated independently. Simultaneous hits give `hit_player` = 2'b11 and a single transition.
- On a hit:
  - `hit_player` latches the hit vector and holds it until Reset.
  - `bump_pulse` = 1 for exactly one frame.
  - State goes to BUMP with `bump_cnt` = 0.
- BUMP:
  - `bump_cnt` increments 0..7.
  - `bump_offset` follows {2,4,6,6,4,2,0,0} indexed by `bump_cnt`.
  - After `bump_cnt` = 7, state goes to EMPTY.
- Level left mid-BUMP (!`in_level`): go directly to EMPTY and set `bump_offset` = 0. The contents are still counted as delivered.
- EMPTY: `is_qblock_empty` = 1, `bump_offset` = 0; all hits are ignored.
- `start_x` = `block_x` and `start_y` = `block_y` − 20 (one tile above). Both are combinational and valid at all times.
- Render path (combinational):
  - px = DrawX − `block_x` + 10
  - py = DrawY − (`block_y` − `bump_offset`) + 10
  - `is_qblock` = `in_level` && px ∈ [0,19] && py ∈ [0,19]
  - `qblock_address` = px + 20·py when `is_qblock`, otherwise 0
  - Sprite selection between full and empty art is external, keyed on `is_qblock_empty`.

## Timing
- Reset values: state FULL, `is_qblock_empty` 0, `bump_pulse` 0, `hit_player` 0, `bump_offset` 0, `bump_cnt` 0, prev heads 0, `track_valid` 0.
- Reset asserted mid-BUMP or in EMPTY returns the block to FULL asynchronously.
- Hit sampled at edge N:
  - `bump_pulse` = 1 and `bump_offset` = 2 after edge N.
  - `bump_pulse` = 0 after edge N+1.
  - Offsets after edges N+1..N+7 are 4,6,6,4,2,0,0.
  - `is_qblock_empty` = 1 after edge N+8.
- The first hit is possible one frame after level entry, once `track_valid` is set.
- The upgrade block sees `is_qblock_empty` in the same frame it rises.

## Configuration
- `QBLOCK_BUMP_ANIM_EN` defined: BUMP state and offset sequence exactly as above.
- Not defined:
  - BUMP state is removed.
  - A hit at edge N sets EMPTY, `is_qblock_empty` = 1 and `bump_pulse` = 1 after edge N.
  - `bump_offset` is tied to 0.
  - `hit_player` behaves the same as with the macro defined.

## Test plan
- Block (200,200), in level. Mario x = 200, Size_Y = 10, y moving 228 → 216 (head 218 → 206) → `bump_pulse` on that edge, `hit_player` = 01; offsets 2,4,6,6,4,2,0,0; `is_qblock_empty` = 1 eight frames later.
- Same geometry with Mario moving down (head 206 → 208), or with `mario_health` = 0 → no hit, state stays FULL.
- Mario and Luigi both rising into the block on the same frame → `hit_player` = 11, a single `bump_pulse`.
- Level changes at `bump_cnt` = 3 → EMPTY on next edge, `bump_offset` = 0, `is_qblock_empty` = 1; re-enter the level → still EMPTY and `is_qblock` drawn.
- Reset pulsed while EMPTY → `is_qblock_empty` 0, `hit_player` 0; a hit immediately on the first in-level frame is rejected until `track_valid` is set.
- Render check at `bump_offset` = 6: DrawX = 190, DrawY = 184 → `is_qblock` = 1, address 0; DrawX = 209, DrawY = 203 → address 399; DrawY = 204 → `is_qblock` = 0.
